// File: rtl/sub_div.sv
// rtl/sub_div.sv - unsigned restoring shift-subtract divider, one quotient bit per clock
module sub_div #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DIV0
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WIDTH);

    state_t           state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;
    logic             zero_pend;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             accept;

    // One restoring step: the extra borrow bit beyond the 9-bit difference marks a negative result.
    always_comb begin
        shifted  = (rem << 1) | {{WIDTH{1'b0}}, dividend[WIDTH-1]};
        {borrow, diff} = {1'b0, shifted} - {2'b00, divisor};
        rem_next = borrow ? shifted : diff;
        quo_next = (quo << 1) | {{(WIDTH-1){1'b0}}, ~borrow};
    end

    // A divide-by-zero FIN cycle still has its result pending, so it does not take a new request.
    assign accept = START && ((state == IDLE) || ((state == FIN) && !zero_pend));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            dividend  <= '0;
            divisor   <= '0;
            quo       <= '0;
            rem       <= '0;
            zero_pend <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            Q         <= '0;
            R         <= '0;
            DIV0      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (accept) begin
                dividend <= A;
                divisor  <= B;
                rem      <= '0;
                quo      <= '0;
                if (B != '0) begin
                    state <= RUN;
                    BUSY  <= 1'b1;
                    cnt   <= CNT_INIT;
                end else begin
                    state     <= FIN;
                    zero_pend <= 1'b1;
                    cnt       <= '0;
                end
            end else begin
                case (state)
                    RUN: begin
                        dividend <= dividend << 1;
                        rem      <= rem_next;
                        quo      <= quo_next;
                        if (cnt <= 4'd1) begin
                            cnt   <= '0;
                            state <= FIN;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            Q     <= quo_next;
                            R     <= rem_next[WIDTH-1:0];
                            DIV0  <= 1'b0;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    FIN: begin
                        if (zero_pend) begin
                            zero_pend <= 1'b0;
                            DONE      <= 1'b1;
                            Q         <= '1;
                            R         <= dividend;
                            DIV0      <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
